alu_issue_seq: RTL and testbench

Issue/sequencing stage directly upstream of the 32-bit execute ALU (ALU32).
- Accepts one ALU request per transaction over a valid/ready handshake and drives the ALU's in0/in1/op inputs.
- ALU32 shifts by exactly one bit per pass, so this block runs shamt passes for SLL/SRL/SRA, feeding each result back.
- Returns the final result over a valid/ready response handshake.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_issue_seq.sv | 135 +++++++++++++
 tb/tb_alu_issue_seq.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
//============================================================================
// alu_pkg : ALU32 opcode constants, shift classification, issue-FSM states
// Revision: 1.0
//============================================================================
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'd0;
   localparam logic [2:0] ALU_OR  = 3'd1;
   localparam logic [2:0] ALU_ADD = 3'd2;
   localparam logic [2:0] ALU_SUB = 3'd3;
   localparam logic [2:0] ALU_SRA = 3'd4;
   localparam logic [2:0] ALU_NOR = 3'd5;
   localparam logic [2:0] ALU_SRL = 3'd6;
   localparam logic [2:0] ALU_SLL = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } issue_state_t;

   function automatic logic is_shift(input logic [2:0] op);
      return (op == ALU_SRA) || (op == ALU_SRL) || (op == ALU_SLL);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_seq.sv
`default_nettype none
//============================================================================
// alu_issue_seq : issue/sequencing stage in front of ALU32; iterates
//                 single-bit shifts and returns results over valid/ready
// Revision: 1.0
//============================================================================
module alu_issue_seq
   import alu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [2:0]         req_op,
   input  logic [XLEN-1:0]    req_a,
   input  logic [XLEN-1:0]    req_b,
   input  logic [SHAMT_W-1:0] req_shamt,
   output logic [XLEN-1:0]    alu_in0,
   output logic [XLEN-1:0]    alu_in1,
   output logic [2:0]         alu_op,
   input  logic [XLEN-1:0]    alu_out,
   input  logic               alu_of,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [XLEN-1:0]    rsp_data,
   output logic               rsp_of,
   output logic               rsp_zero,
   output logic               busy
);

   issue_state_t        state, state_d;
   logic [2:0]          op_q, op_d;
   logic [XLEN-1:0]     a_q, a_d, b_q, b_d, acc, acc_d;
   logic [SHAMT_W-1:0]  cnt, cnt_d;
   logic [XLEN-1:0]     data_d;
   logic                of_d, zero_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc      <= '0;
         cnt      <= '0;
         rsp_data <= '0;
         rsp_of   <= 1'b0;
         rsp_zero <= 1'b0;
      end else begin
         state    <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc      <= acc_d;
         cnt      <= cnt_d;
         rsp_data <= data_d;
         rsp_of   <= of_d;
         rsp_zero <= zero_d;
      end
   end

   always_comb begin
      state_d   = state;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc;
      cnt_d     = cnt;
      data_d    = rsp_data;
      of_d      = rsp_of;
      zero_d    = rsp_zero;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      alu_in0   = '0;
      alu_in1   = '0;
      alu_op    = ALU_AND;
      busy      = (state != ST_IDLE);

      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               op_d  = req_op;
               a_d   = req_a;
               b_d   = req_b;
               cnt_d = req_shamt;
               if (!is_shift(req_op)) begin
                  state_d = ST_EXEC;
               end else if (req_shamt == '0) begin
                  // Zero-length shift bypasses the ALU entirely.
                  data_d  = req_a;
                  of_d    = 1'b0;
                  zero_d  = (req_a == '0);
                  state_d = ST_DONE;
               end else begin
                  acc_d   = req_a;
                  state_d = ST_SHIFT;
               end
            end
         end
         ST_EXEC: begin
            alu_in0 = a_q;
            alu_in1 = b_q;
            alu_op  = op_q;
            data_d  = alu_out;
            of_d    = ((op_q == ALU_ADD) || (op_q == ALU_SUB)) && alu_of;
            zero_d  = (alu_out == '0);
            state_d = ST_DONE;
         end
         ST_SHIFT: begin
            alu_in0 = acc;
            alu_op  = op_q;
            acc_d   = alu_out;
            cnt_d   = cnt - SHAMT_W'(1);
            // cnt is at least 1 here, so the final pass never wraps it.
            if (cnt == SHAMT_W'(1)) begin
               data_d  = alu_out;
               of_d    = 1'b0;
               zero_d  = (alu_out == '0);
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_seq.sv
`default_nettype none
//============================================================================
// tb_alu_issue_seq : directed and randomized checks of alu_issue_seq
//                    against an arithmetic reference model
// Revision: 1.0
//============================================================================
module tb_alu_issue_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = '0;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic [4:0]  req_shamt = '0;
   logic [31:0] alu_in0, alu_in1, alu_out;
   logic [2:0]  alu_op;
   logic        alu_of;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        rsp_of, rsp_zero, busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_issue_seq #(.XLEN(32), .SHAMT_W(5)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
      .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_op(alu_op),
      .alu_out(alu_out), .alu_of(alu_of),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_of(rsp_of), .rsp_zero(rsp_zero), .busy(busy)
   );

   // ALU32 model: one-bit shifts; flag is carry (ADD) / borrow (SUB).
   // For logic/shift ops the flag is driven with the result MSB so that
   // the issue stage's flag gating is actually exercised.
   logic [32:0] sum;
   always_comb begin
      sum     = {1'b0, alu_in0} + {1'b0, alu_in1};
      alu_out = '0;
      alu_of  = 1'b0;
      case (alu_op)
         3'd0: alu_out = alu_in0 & alu_in1;
         3'd1: alu_out = alu_in0 | alu_in1;
         3'd2: alu_out = sum[31:0];
         3'd3: alu_out = alu_in0 - alu_in1;
         3'd4: alu_out = {alu_in0[31], alu_in0[31:1]};
         3'd5: alu_out = ~(alu_in0 | alu_in1);
         3'd6: alu_out = {1'b0, alu_in0[31:1]};
         3'd7: alu_out = {alu_in0[30:0], 1'b0};
         default: alu_out = '0;
      endcase
      if (alu_op == 3'd2)      alu_of = sum[32];
      else if (alu_op == 3'd3) alu_of = (alu_in0 < alu_in1);
      else                     alu_of = alu_out[31];
   end

   // Reference: whole-operation result {of, data} from plain arithmetic.
   function automatic logic [32:0] ref_result(input logic [2:0] op,
         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
      logic [31:0] t;
      logic [32:0] s;
      case (op)
         3'd0: return {1'b0, a & b};
         3'd1: return {1'b0, a | b};
         3'd2: begin s = {1'b0, a} + {1'b0, b}; return s; end
         3'd3: return {(a < b), a - b};
         3'd4: begin t = $signed(a) >>> sh; return {1'b0, t}; end
         3'd5: return {1'b0, ~(a | b)};
         3'd6: return {1'b0, a >> sh};
         default: return {1'b0, a << sh};
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] op, input logic [4:0] sh);
      if (op == 3'd4 || op == 3'd6 || op == 3'd7) return (sh == 0) ? 1 : 1 + int'(sh);
      return 2;
   endfunction

   // Drives one request and collects the response; hold = cycles of
   // backpressure after rsp_valid rises. Returns observations only.
   task automatic run_txn(input logic [2:0] op, input logic [31:0] a,
         input logic [31:0] b, input logic [4:0] sh, input int hold,
         output logic [31:0] d, output logic of, output logic z,
         output int lat, output logic stable, output logic alu_nz);
      int bound;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_shamt = sh;
      rsp_ready = 1'b0;
      alu_nz = (alu_op != 3'd0);
      bound = 0;
      while (!req_ready && bound < 100) begin
         @(negedge clk);
         bound++;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      alu_nz = alu_nz | (alu_op != 3'd0);
      while (!rsp_valid && lat < 100) begin
         @(negedge clk);
         lat++;
         alu_nz = alu_nz | (alu_op != 3'd0);
      end
      d = rsp_data; of = rsp_of; z = rsp_zero;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (rsp_data !== d || rsp_of !== of || rsp_zero !== z ||
             rsp_valid !== 1'b1 || req_ready !== 1'b0) stable = 1'b0;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, rsp_valid, rsp_data, rsp_of, rsp_zero} !== 36'd0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b valid=%b data=%h of=%b zero=%b ready=%b, required 0 0 0 0 0 1",
                  busy, rsp_valid, rsp_data, rsp_of, rsp_zero, req_ready);
      end
      checks++;
      if ({alu_in0, alu_in1, alu_op} !== 67'd0) begin
         errors++;
         $display("FAIL reset_alu_idle: in0=%h in1=%h op=%0d, required all zero", alu_in0, alu_in1, alu_op);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_arith();
      logic [31:0] d; logic of, z, st, nz; int lat;
      run_txn(3'd2, 32'd5, 32'd7, 5'd0, 0, d, of, z, lat, st, nz);
      checks++;
      if (lat !== 2 || d !== 32'd12 || of !== 1'b0 || z !== 1'b0) begin
         errors++;
         $display("FAIL add_5_7: lat=%0d data=%h of=%b zero=%b, required 2 0000000c 0 0", lat, d, of, z);
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL add_ready_again: req_ready=%b, required 1", req_ready);
      end
      run_txn(3'd3, 32'd3, 32'd3, 5'd0, 0, d, of, z, lat, st, nz);
      checks++;
      if (d !== 32'd0 || z !== 1'b1 || of !== 1'b0) begin
         errors++;
         $display("FAIL sub_3_3: data=%h zero=%b of=%b, required 0 1 0", d, z, of);
      end
      run_txn(3'd2, 32'hFFFF_FFFF, 32'd1, 5'd0, 0, d, of, z, lat, st, nz);
      checks++;
      if (d !== 32'd0 || of !== 1'b1 || z !== 1'b1) begin
         errors++;
         $display("FAIL add_carry: data=%h of=%b zero=%b, required 0 1 1", d, of, z);
      end
      run_txn(3'd5, 32'h0F0F_0000, 32'h0000_00FF, 5'd0, 0, d, of, z, lat, st, nz);
      checks++;
      if (d !== 32'hF0F0_FF00 || of !== 1'b0) begin
         errors++;
         $display("FAIL nor_of_gated: data=%h of=%b, required f0f0ff00 0", d, of);
      end
   endtask

   task automatic test_shift();
      logic [31:0] d; logic of, z, st, nz; int lat;
      run_txn(3'd7, 32'd1, 32'hDEAD_BEEF, 5'd31, 0, d, of, z, lat, st, nz);
      checks++;
      if (lat !== 32 || d !== 32'h8000_0000 || of !== 1'b0) begin
         errors++;
         $display("FAIL sll_31: lat=%0d data=%h of=%b, required 32 80000000 0", lat, d, of);
      end
      run_txn(3'd4, 32'h8000_0000, 32'd0, 5'd4, 0, d, of, z, lat, st, nz);
      checks++;
      if (lat !== 5 || d !== 32'hF800_0000 || of !== 1'b0) begin
         errors++;
         $display("FAIL sra_4: lat=%0d data=%h of=%b, required 5 f8000000 0", lat, d, of);
      end
      run_txn(3'd6, 32'h8000_0000, 32'd0, 5'd4, 0, d, of, z, lat, st, nz);
      checks++;
      if (lat !== 5 || d !== 32'h0800_0000) begin
         errors++;
         $display("FAIL srl_4: lat=%0d data=%h, required 5 08000000", lat, d);
      end
      run_txn(3'd6, 32'h0000_1234, 32'd9, 5'd0, 0, d, of, z, lat, st, nz);
      checks++;
      if (lat !== 1 || d !== 32'h1234 || nz !== 1'b0 || z !== 1'b0) begin
         errors++;
         $display("FAIL srl_0: lat=%0d data=%h alu_op_used=%b zero=%b, required 1 00001234 0 0", lat, d, nz, z);
      end
   endtask

   task automatic test_backpressure();
      int bound;
      logic held;
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd0; req_a = 32'hF0F0_F0F0; req_b = 32'hFF00_FF00; req_shamt = '0;
      @(posedge clk);
      @(negedge clk);
      // Second request is presented immediately and held.
      req_op = 3'd1; req_a = 32'd1; req_b = 32'd2;
      bound = 0;
      while (!rsp_valid && bound < 10) begin @(negedge clk); bound++; end
      held = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (rsp_valid !== 1'b1 || rsp_data !== 32'hF000_F000 || rsp_of !== 1'b0 ||
             rsp_zero !== 1'b0 || req_ready !== 1'b0) held = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (!held) begin
         errors++;
         $display("FAIL bp_hold: valid=%b data=%h ready=%b, required 1 f000f000 0 for 5 cycles",
                  rsp_valid, rsp_data, req_ready);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: busy=%b ready=%b valid=%b, required 0 1 0", busy, req_ready, rsp_valid);
      end
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_second_accept: busy=%b ready=%b, required 1 0", busy, req_ready);
      end
      bound = 0;
      while (!rsp_valid && bound < 10) begin @(negedge clk); bound++; end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd3) begin
         errors++;
         $display("FAIL bp_second_result: valid=%b data=%h, required 1 00000003", rsp_valid, rsp_data);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_shift();
      logic [31:0] d; logic of, z, st, nz, seen; int lat;
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd7; req_a = 32'd1; req_b = '0; req_shamt = 5'd20;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 32'd0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_shift: busy=%b valid=%b data=%h ready=%b, required 0 0 0 1",
                  busy, rsp_valid, rsp_data, req_ready);
      end
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen = seen | rsp_valid;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL rst_no_response: rsp_valid seen=%b, required 0", seen);
      end
      run_txn(3'd1, 32'd1, 32'd2, 5'd0, 0, d, of, z, lat, st, nz);
      checks++;
      if (d !== 32'd3 || lat !== 2) begin
         errors++;
         $display("FAIL rst_then_or: data=%h lat=%0d, required 00000003 2", d, lat);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, d; logic [2:0] op; logic [4:0] sh;
      logic of, z, st, nz; int lat, hold;
      logic [32:0] exp;
      for (int n = 0; n < 40; n++) begin
         op   = 3'($urandom_range(0, 7));
         a    = $urandom;
         b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
         sh   = 5'($urandom_range(0, 31));
         hold = $urandom_range(0, 3);
         run_txn(op, a, b, sh, hold, d, of, z, lat, st, nz);
         exp = ref_result(op, a, b, sh);
         checks++;
         if (d !== exp[31:0] || of !== exp[32] || z !== (exp[31:0] == 32'd0) ||
             lat !== ref_latency(op, sh) || st !== 1'b1) begin
            errors++;
            $display("FAIL rand_%0d op=%0d a=%h b=%h sh=%0d: data=%h of=%b zero=%b lat=%0d stable=%b, required %h %b %b %0d 1",
                     n, op, a, b, sh, d, of, z, lat, st,
                     exp[31:0], exp[32], (exp[31:0] == 32'd0), ref_latency(op, sh));
         end
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_shift();
      test_backpressure();
      test_reset_mid_shift();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
